// File: rtl/hazard_pkg.sv
// Shared types and constants for the IF/ID hazard controller.
// The multiply/divide timer is built only when HAZ_MULDIV_EN is defined.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         STALLCNT_W = 16;
  localparam int         MD_CNT_W   = 4;

endpackage

// File: rtl/hazard_md_timer.sv
// RUN/MD_WAIT sequencer for multi-cycle multiply/divide occupancy of EX.
// A start in RUN opens a window of MULDIV_CYCLES stall cycles including the start cycle.
module hazard_md_timer
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic      Clk_in,
  input  logic      Rst_in,
  input  logic      start,
  input  logic      hold,
  output hz_state_e state,
  output logic      md_active
);

  // Cycles remaining after the start cycle and the first MD_WAIT cycle.
  localparam logic [MD_CNT_W-1:0] MD_LOAD =
    MD_CNT_W'((MULDIV_CYCLES > 1) ? (MULDIV_CYCLES - 2) : 0);

  hz_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_active = 1'b0;
    case (state_q)
      RUN: begin
        md_active = start;
        if (start && !hold && (MULDIV_CYCLES > 1)) begin
          state_d = MD_WAIT;
          cnt_d   = MD_LOAD;
        end
      end
      MD_WAIT: begin
        md_active = 1'b1;
        // A taken branch freezes the sequencer for that cycle.
        if (!hold) begin
          if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// Front-end hazard controller: advance/hold/flush for PC, IF/ID, ID/EX and EX/MEM, plus a stall counter.
// Optional multiply/divide freeze is enabled by defining HAZ_MULDIV_EN.
module if_id_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                  Clk_in,
  input  logic                  Rst_in,
  input  logic [4:0]            IDRs_in,
  input  logic [4:0]            IDRt_in,
  input  logic                  IDUsesRt_in,
  input  logic                  EXMemRead_in,
  input  logic [4:0]            EXRt_in,
  input  logic                  BranchTaken_in,
  input  logic                  MulDivStart_in,
  output logic                  PCWrite_out,
  output logic                  IFIDWrite_out,
  output logic                  IFIDFlush_out,
  output logic                  IDEXWrite_out,
  output logic                  IDEXBubble_out,
  output logic                  EXMEMBubble_out,
  output logic                  Busy_out,
  output logic [STALLCNT_W-1:0] StallCnt_out
);

  logic load_use;
  logic md_stall;

  assign load_use = EXMemRead_in && (EXRt_in != REG_ZERO) &&
                    ((EXRt_in == IDRs_in) || (IDUsesRt_in && (EXRt_in == IDRt_in)));

`ifdef HAZ_MULDIV_EN
  hz_state_e md_state;

  hazard_md_timer #(
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) u_md_timer (
    .Clk_in    (Clk_in),
    .Rst_in    (Rst_in),
    .start     (MulDivStart_in),
    .hold      (BranchTaken_in),
    .state     (md_state),
    .md_active (md_stall)
  );
`else
  logic unused_md;
  assign unused_md = MulDivStart_in ^ (MULDIV_CYCLES > 1);
  assign md_stall  = 1'b0;
`endif

  // Priority: reset, branch flush, multiply/divide stall, load-use stall, normal.
  always_comb begin
    PCWrite_out     = 1'b1;
    IFIDWrite_out   = 1'b1;
    IFIDFlush_out   = 1'b0;
    IDEXWrite_out   = 1'b1;
    IDEXBubble_out  = 1'b0;
    EXMEMBubble_out = 1'b0;
    Busy_out        = 1'b0;
    if (Rst_in) begin
      PCWrite_out     = 1'b0;
      IFIDWrite_out   = 1'b0;
      IFIDFlush_out   = 1'b1;
      IDEXBubble_out  = 1'b1;
      EXMEMBubble_out = 1'b1;
    end else if (BranchTaken_in) begin
      IFIDFlush_out  = 1'b1;
      IDEXBubble_out = 1'b1;
    end else if (md_stall) begin
      PCWrite_out     = 1'b0;
      IFIDWrite_out   = 1'b0;
`ifdef HAZ_MULDIV_EN
      IDEXWrite_out   = 1'b0;
`endif
      EXMEMBubble_out = 1'b1;
      Busy_out        = 1'b1;
    end else if (load_use) begin
      PCWrite_out    = 1'b0;
      IFIDWrite_out  = 1'b0;
      IDEXBubble_out = 1'b1;
    end
  end

  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      StallCnt_out <= '0;
    end else if (!PCWrite_out && (StallCnt_out != {STALLCNT_W{1'b1}})) begin
      StallCnt_out <= StallCnt_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench for if_id_hazard_ctrl: directed vectors push expected outputs, a monitor compares.
// Multiply/divide vectors run only when HAZ_MULDIV_EN is defined.
module tb_if_id_hazard_ctrl;

  // Control bits: PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble, Busy
  localparam logic [6:0] C_NORM = 7'b1101000;
  localparam logic [6:0] C_RST  = 7'b0011110;
  localparam logic [6:0] C_BR   = 7'b1111100;
  localparam logic [6:0] C_LU   = 7'b0001100;
  localparam logic [6:0] C_MD   = 7'b0000011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, br_taken = 1'b0, md_start = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, busy;
  logic [15:0] stall_cnt;

  logic [22:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
  bit          drive_done = 1'b0;

  if_id_hazard_ctrl #(.MULDIV_CYCLES(4)) dut (
    .Clk_in          (clk),
    .Rst_in          (rst),
    .IDRs_in         (id_rs),
    .IDRt_in         (id_rt),
    .IDUsesRt_in     (id_uses_rt),
    .EXMemRead_in    (ex_mem_read),
    .EXRt_in         (ex_rt),
    .BranchTaken_in  (br_taken),
    .MulDivStart_in  (md_start),
    .PCWrite_out     (pc_write),
    .IFIDWrite_out   (ifid_write),
    .IFIDFlush_out   (ifid_flush),
    .IDEXWrite_out   (idex_write),
    .IDEXBubble_out  (idex_bubble),
    .EXMEMBubble_out (exmem_bubble),
    .Busy_out        (busy),
    .StallCnt_out    (stall_cnt)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // Driver: one vector per cycle, applied just after the rising edge.
  task automatic drive(input string nm, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mrd, input logic [4:0] ert,
                       input logic br, input logic mds, input logic [6:0] ctrl);
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_mem_read = mrd; ex_rt = ert; br_taken = br; md_start = mds;
    exp_q.push_back({ctrl, exp_cnt});
    name_q.push_back(nm);
    if (r) exp_cnt = '0;
    else if (!ctrl[6] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] exp_v, got_v;
      string       nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, busy, stall_cnt};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                 nm, got_v[22:16], got_v[15:0], exp_v[22:16], exp_v[15:0]);
      end
    end
  end

  initial begin
    // Hold reset across the first edge so the counter is defined.
    @(posedge clk);
    //     name         rst rs     rt     urt mrd ert    br   mds  expected
    drive("reset",      1, 5'd0,  5'd0,  0,  0,  5'd0,  0,   0,   C_RST);
    drive("idle",       0, 5'd1,  5'd2,  1,  0,  5'd0,  0,   0,   C_NORM);
    drive("lu_rs",      0, 5'd8,  5'd2,  0,  1,  5'd8,  0,   0,   C_LU);
    drive("after_lu",   0, 5'd8,  5'd2,  0,  0,  5'd8,  0,   0,   C_NORM);
    drive("lu_rt",      0, 5'd3,  5'd9,  1,  1,  5'd9,  0,   0,   C_LU);
    drive("load_zero",  0, 5'd0,  5'd0,  1,  1,  5'd0,  0,   0,   C_NORM);
    drive("rt_unused",  0, 5'd3,  5'd9,  0,  1,  5'd9,  0,   0,   C_NORM);
    drive("no_load",    0, 5'd8,  5'd8,  1,  0,  5'd8,  0,   0,   C_NORM);
    drive("br_over_lu", 0, 5'd8,  5'd2,  0,  1,  5'd8,  1,   0,   C_BR);
    drive("after_br",   0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   0,   C_NORM);
`ifdef HAZ_MULDIV_EN
    drive("md_c1_lu",   0, 5'd8,  5'd2,  0,  1,  5'd8,  0,   1,   C_MD);
    drive("md_c2_lu",   0, 5'd8,  5'd2,  0,  1,  5'd8,  0,   0,   C_MD);
    drive("md_c3_start",0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   1,   C_MD);
    drive("md_c4",      0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   0,   C_MD);
    drive("md_done",    0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   0,   C_NORM);
    drive("md2_c1",     0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   1,   C_MD);
    drive("md2_rst",    1, 5'd1,  5'd2,  0,  0,  5'd0,  0,   0,   C_RST);
    drive("md2_after",  0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   0,   C_NORM);
    drive("md2_idle",   0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   0,   C_NORM);
`else
    drive("md_ignored", 0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   1,   C_NORM);
    drive("md_ign_lu",  0, 5'd8,  5'd2,  0,  1,  5'd8,  0,   1,   C_LU);
    drive("md_after",   0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   0,   C_NORM);
`endif
    // Saturation: clear, then hold a load-use hazard for 70000 cycles.
    drive("sat_reset",  1, 5'd0,  5'd0,  0,  0,  5'd0,  0,   0,   C_RST);
    for (int i = 0; i < 70000; i++) begin
      drive("sat_lu",   0, 5'd7,  5'd0,  0,  1,  5'd7,  0,   0,   C_LU);
    end
    drive("sat_hold",   0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   0,   C_NORM);
    drive("sat_final",  0, 5'd1,  5'd2,  0,  0,  5'd0,  0,   0,   C_NORM);
    drive_done = 1'b1;
  end

  // Final report
  initial begin
    wait (drive_done);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_ctrl.md
# if_id_hazard_ctrl

Hazard controller that sequences the IF/ID pipeline register and the PC. It decides each cycle whether the front end advances, holds or flushes. It detects load-use hazards against the instruction in ID and flushes wrong-path fetches on a taken branch resolved in EX. It also freezes the front end while a multi-cycle multiply/divide occupies EX, and counts stall cycles for performance monitoring.

## Interface
- MULDIV_CYCLES, 4: total EX occupancy of a multiply/divide; legal range 1..15
- Clk_in  in  1  pipeline clock; all state changes on its rising edge
- Rst_in  in  1  synchronous, active-high reset
- IDRs_in  in  5  rs field of the instruction in ID
- IDRt_in  in  5  rt field of the instruction in ID
- IDUsesRt_in  in  1  the ID instruction reads rt as a source
- EXMemRead_in  in  1  the instruction in EX is a load
- EXRt_in  in  5  destination register of the load in EX
- BranchTaken_in  in  1  the branch in EX resolved taken this cycle
- MulDivStart_in  in  1  a multiply/divide is in EX for its first cycle
- PCWrite_out  out  1  PC update enable
- IFIDWrite_out  out  1  IF/ID register load enable
- IFIDFlush_out  out  1  IF/ID register loads a NOP
- IDEXWrite_out  out  1  ID/EX register load enable
- IDEXBubble_out  out  1  ID/EX register loads a bubble
- EXMEMBubble_out  out  1  EX/MEM register loads a bubble
- Busy_out  out  1  a multiply/divide stall is in progress
- StallCnt_out  out  16  saturating count of cycles with PCWrite_out=0

## Operation
- States: RUN and MD_WAIT. A 4-bit countdown register is used in MD_WAIT.
- Control outputs are combinational from the current state and the inputs. State, countdown and StallCnt are registered.
- Load-use hazard (LU): EXMemRead_in && EXRt_in!=0 && (EXRt_in==IDRs_in || (IDUsesRt_in && EXRt_in==IDRt_in)).
- Priority, highest first: reset, branch flush, multiply/divide stall, LU stall, normal.
- Normal: PCWrite=1, IFIDWrite=1, IDEXWrite=1, all other outputs 0.
- Branch flush (BranchTaken_in=1):
  - Outputs: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXWrite=1, IDEXBubble=1.
  - LU and MulDivStart_in are ignored that cycle.
  - The state is unchanged.
- Multiply/divide stall (MulDivStart_in=1 in RUN, or any cycle in MD_WAIT):
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1, IDEXBubble=0, Busy=1.
  - LU is suppressed.
- RUN to MD_WAIT: on MulDivStart_in with MULDIV_CYCLES>1; the countdown loads MULDIV_CYCLES-2.
- MD_WAIT: the countdown decrements each cycle. The state returns to RUN on the cycle after the countdown reaches 0.
- MulDivStart_in is ignored while in MD_WAIT.
- LU stall: PCWrite=0, IFIDWrite=0, IDEXWrite=1, IDEXBubble=1.
- StallCnt: increments by 1 on each non-reset cycle with PCWrite_out=0. It holds at 0xFFFF.

## Timing
- Hazard outputs take effect in the same cycle as the causing inputs (zero latency).
- LU stall lasts exactly 1 cycle, because the load advances out of EX.
- Multiply/divide stall lasts exactly MULDIV_CYCLES cycles, including the start cycle. With MULDIV_CYCLES=1 there is only the start cycle and no MD_WAIT.
- Output values while Rst_in=1:
  - PCWrite=0, IFIDWrite=0
  - IFIDFlush=1, IDEXWrite=1, IDEXBubble=1, EXMEMBubble=1
  - Busy=0
- After the reset edge: state=RUN, countdown=0, StallCnt_out=0.
- Reset in MD_WAIT aborts the stall; RUN applies on the next cycle.
- StallCnt_out is registered; it reflects a stall one cycle after that stall.

## Configuration
- HAZ_MULDIV_EN defined: multiply/divide stall logic and MD_WAIT are present.
- HAZ_MULDIV_EN undefined:
  - MulDivStart_in is ignored and there is no state register beyond StallCnt.
  - Busy_out is tied 0.
  - IDEXWrite_out is tied 1.
  - EXMEMBubble_out is 0 except during reset.
  - MULDIV_CYCLES is unused.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, MD_WAIT)
  - the REG_ZERO constant (5'd0)
  - the STALLCNT_W=16 constant
- Sub-module hazard_md_timer holds the countdown and the RUN/MD_WAIT state. It is instantiated only under HAZ_MULDIV_EN.

## Test plan
- Load-use on rs: EXMemRead=1, EXRt=8, IDRs=8 for 1 cycle -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 that cycle; normal outputs next cycle; StallCnt_out=1 one cycle later.
- Load to $zero: EXMemRead=1, EXRt=0, IDRs=0 -> no stall. Rt match with IDUsesRt_in=0 -> no stall.
- Branch taken during load-use: BranchTaken=1 with LU true -> IFIDFlush=1, PCWrite=1, IDEXBubble=1, no stall count.
- Multiply/divide, MULDIV_CYCLES=4: MulDivStart pulse -> Busy=1 and PCWrite=0 for exactly 4 cycles, EXMEMBubble=1 each cycle, then RUN. A concurrent LU during this window -> no IDEXBubble.
- Reset during MD_WAIT cycle 2 -> reset outputs that cycle; next cycle state=RUN, Busy=0, StallCnt_out=0.
- Saturation: hold an LU condition for 70000 cycles -> StallCnt_out stops at 0xFFFF.
